// File: rtl/msrv32_bus_arbiter.sv
// Shares one memory bus between instruction fetch and load/store data accesses.
// Latency: request -> bus_req_out next cycle; bus_ack_in -> requester ack next cycle.
// Backpressure: requesters hold req until their ack; data has priority, fetch forced after FAIR_LIMIT data wins.
module msrv32_bus_arbiter #(
    parameter int unsigned FAIR_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        i_req_in,
    input  logic [31:0] i_addr_in,
    output logic        i_ack_out,
    output logic [31:0] i_rdata_out,
    input  logic        d_req_in,
    input  logic        d_we_in,
    input  logic [3:0]  d_wmask_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    output logic        d_ack_out,
    output logic [31:0] d_rdata_out,
    output logic        bus_req_out,
    output logic        bus_we_out,
    output logic [3:0]  bus_wmask_out,
    output logic [31:0] bus_addr_out,
    output logic [31:0] bus_wdata_out,
    input  logic        bus_ack_in,
    input  logic [31:0] bus_rdata_in,
    output logic        owner_out,
    output logic        busy_out
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(FAIR_LIMIT);

    state_t      state_q;
    logic [3:0]  streak_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [3:0]  bus_wmask_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic        i_ack_q;
    logic        d_ack_q;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;
    logic        owner_q;
    logic        busy_q;

    // Data wins unless fetch has already waited through LIMIT data grants.
    logic streak_full;
    logic grant_data;
    logic grant_fetch;
    assign streak_full = (streak_q == LIMIT);
    assign grant_data  = d_req_in && !(i_req_in && streak_full);
    assign grant_fetch = i_req_in && !grant_data;

    // Arbitration FSM with all bus and response outputs registered.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_wmask_q <= 4'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Acks are single-cycle pulses; only the ack edge below raises them.
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= d_we_in;
                        bus_wmask_q <= d_wmask_in;
                        bus_addr_q  <= d_addr_in;
                        bus_wdata_q <= d_wdata_in;
                        owner_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= DATA;
                        // Only count wins that actually made fetch wait.
                        if (i_req_in)
                            streak_q <= streak_full ? LIMIT : streak_q + 4'd1;
                        else
                            streak_q <= 4'd0;
                    end else if (grant_fetch) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_wmask_q <= 4'd0;
                        bus_addr_q  <= i_addr_in;
                        bus_wdata_q <= 32'd0;
                        owner_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= FETCH;
                        streak_q    <= 4'd0;
                    end
                end
                FETCH, DATA: begin
                    if (bus_ack_in) begin
                        bus_req_q <= 1'b0;
                        state_q   <= RESP;
                        if (state_q == FETCH) begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= bus_rdata_in;
                        end else begin
                            d_ack_q <= 1'b1;
                            if (!bus_we_q)
                                d_rdata_q <= bus_rdata_in;
                        end
                    end
                end
                RESP: begin
                    // One quiet cycle lets the requester drop its satisfied request.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req_out   = bus_req_q;
    assign bus_we_out    = bus_we_q;
    assign bus_wmask_out = bus_wmask_q;
    assign bus_addr_out  = bus_addr_q;
    assign bus_wdata_out = bus_wdata_q;
    assign i_ack_out     = i_ack_q;
    assign d_ack_out     = d_ack_q;
    assign i_rdata_out   = i_rdata_q;
    assign d_rdata_out   = d_rdata_q;
    assign owner_out     = owner_q;
    assign busy_out      = busy_q;

endmodule

// File: doc/msrv32_bus_arbiter.md
Name: msrv32_bus_arbiter

Overview:
- Shares one external memory bus between instruction fetch and load/store data accesses in the msrv32 core.
- Fixed priority: data wins. A starvation counter guarantees fetch service after FAIR_LIMIT consecutive data grants.
- Registered bus outputs and registered per-requester ack/rdata. Upstream pipeline register stages stall on pending requests.

Parameters:
- FAIR_LIMIT, 4, consecutive data grants allowed while fetch pending before fetch is forced; legal 1..15

Ports:
- clk_in  input  1  clock
- reset_in  input  1  reset
- i_req_in  input  1  fetch request, held until i_ack_out
- i_addr_in  input  32  fetch address
- i_ack_out  output  1  one-cycle fetch completion pulse
- i_rdata_out  output  32  fetch read data, valid with i_ack_out
- d_req_in  input  1  data request, held until d_ack_out
- d_we_in  input  1  1 = store, 0 = load
- d_wmask_in  input  4  byte write mask
- d_addr_in  input  32  data address
- d_wdata_in  input  32  store data
- d_ack_out  output  1  one-cycle data completion pulse
- d_rdata_out  output  32  load data, valid with d_ack_out
- bus_req_out  output  1  bus request
- bus_we_out  output  1  bus write enable
- bus_wmask_out  output  4  bus byte mask
- bus_addr_out  output  32  bus address
- bus_wdata_out  output  32  bus write data
- bus_ack_in  input  1  slave completion; bus_rdata_in valid same cycle
- bus_rdata_in  input  32  slave read data
- owner_out  output  1  current/last grant: 0 = fetch, 1 = data
- busy_out  output  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk_in, rising edge. Reset reset_in is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, streak counter 0.
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If only one request is high, grant it.
  - If both are high: grant fetch when streak == FAIR_LIMIT, else grant data.
  - On grant, capture the winner's address, we, wmask and wdata into the bus_* registers (fetch: we=0, wmask=0, wdata=0).
  - On grant, set bus_req_out=1 and owner_out, and go to FETCH or DATA.
- Streak counter:
  - Data grant while i_req_in=1: increment, saturating at FAIR_LIMIT.
  - Any fetch grant: clear to 0.
  - Data grant with i_req_in=0: clear to 0.
- FETCH/DATA:
  - Hold all bus_* outputs stable until bus_ack_in=1.
  - On the ack edge: capture bus_rdata_in into the owner's rdata_out (loads and fetches only; stores leave d_rdata_out unchanged).
  - On the ack edge: bus_req_out←0, pulse the owner's ack_out, go to RESP.
- RESP: ack_out high for exactly this one cycle, then cleared. Always go to IDLE. This gives the requester one cycle to drop or change its request, so no stale request is re-granted.
- Latency:
  - Request high in IDLE at cycle N → bus_req_out=1 at N+1.
  - bus_ack_in at cycle M (M ≥ N+1; zero-wait ack in N+1 is legal) → ack_out=1 at M+1.
  - Next grant possible at M+2; bus_req_out earliest high again at M+3.
- Handshake rules:
  - Requester holds req and its payload stable until ack.
  - If a requester drops req mid-transaction, the transaction still completes and ack is still pulsed.
  - Payload changes after grant are ignored (values captured at grant).
- bus_ack_in in IDLE or RESP: ignored, no state or output change.
- busy_out = (state != IDLE), registered.
- Reset mid-transaction: abandon immediately. No ack is issued, and a later bus_ack_in is ignored.
- i_ack_out and d_ack_out are never high in the same cycle.

Test Plan:
- Fetch only: i_req_in=1, i_addr_in=0x00000100; slave acks 2 cycles after bus_req_out with rdata 0x00000013 → bus_addr_out=0x100, bus_we_out=0, i_ack_out pulses 1 cycle with i_rdata_out=0x00000013, busy_out returns to 0.
- Simultaneous: fetch 0x200 and load 0x8000 asserted same cycle, zero-wait slave → data granted first (owner_out=1, bus_addr_out=0x8000), d_ack_out, then fetch at 0x200 with i_ack_out; acks 3 cycles apart.
- Starvation, FAIR_LIMIT=2: d_req_in held high continuously, i_req_in high → grant order D, D, F, D, D, F; streak reads 0 after each F.
- Store: d_we_in=1, d_wmask_in=4'b0011, d_addr_in=0x10, d_wdata_in=0xDEADBEEF → bus_we_out=1, bus_wmask_out=0011, bus_wdata_out=0xDEADBEEF; d_ack_out pulses; d_rdata_out unchanged.
- Reset during DATA before ack: reset_in pulsed → all outputs 0 immediately; subsequent bus_ack_in produces no d_ack_out; state IDLE.
- Spurious ack: bus_ack_in=1 while IDLE with no requests → no ack_out, bus_req_out stays 0.
